// File: rtl/prog_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | prog_mem : 16 x 8 flop program memory with nibble-serial loader and    |
// | CPU run/hold control. Optional macro PROG_MEM_CHECKSUM_EN adds an XOR   |
// | checksum stage after the last data nibble.            Rev 1.0          |
// +------------------------------------------------------------------------+
module prog_mem #(
    parameter int RESET_RUN = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] addr,
    output logic [7:0] data,
    output logic       cpu_run,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [3:0] ld_nibble,
    output logic       ld_ready,
    output logic       ld_done,
    output logic       ld_err
);

    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_LOAD_HI  = 3'd2;
    localparam logic [2:0] S_LOAD_LO  = 3'd3;
`ifdef PROG_MEM_CHECKSUM_EN
    localparam logic [2:0] S_LOAD_SUM = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;
`endif
    localparam logic [2:0] S_AFTER_RESET = (RESET_RUN != 0) ? S_RUN : S_WAIT;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_mem [16];
    logic [3:0] r_ptr;
    logic [3:0] r_hi;
    logic       r_done;
    logic       w_accept;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [3:0] r_xor;
    logic       r_err;
`endif

    // A restart request wins over a simultaneous handshake, so that nibble is dropped.
    assign w_accept = ld_valid && ld_ready && !ld_start;
    assign data     = r_mem[addr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_AFTER_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (ld_start) begin
            w_next = S_LOAD_HI;
        end else begin
            case (r_state)
                S_LOAD_HI: begin
                    if (w_accept) w_next = S_LOAD_LO;
                end
                S_LOAD_LO: begin
                    if (w_accept) begin
`ifdef PROG_MEM_CHECKSUM_EN
                        w_next = (r_ptr == 4'hF) ? S_LOAD_SUM : S_LOAD_HI;
`else
                        w_next = (r_ptr == 4'hF) ? S_RUN : S_LOAD_HI;
`endif
                    end
                end
`ifdef PROG_MEM_CHECKSUM_EN
                S_LOAD_SUM: begin
                    if (w_accept) w_next = (ld_nibble == r_xor) ? S_RUN : S_ERR;
                end
`endif
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        cpu_run = (r_state == S_RUN);
        ld_done = r_done;
        case (r_state)
            S_LOAD_HI, S_LOAD_LO: ld_ready = 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
            S_LOAD_SUM:           ld_ready = 1'b1;
`endif
            default:              ld_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_ptr  <= 4'h0;
            r_hi   <= 4'h0;
            r_done <= 1'b0;
        end else begin
            // Only a load-terminating accept can move the FSM into RUN.
            r_done <= w_accept && (w_next == S_RUN);
            if (ld_start) begin
                r_ptr <= 4'h0;
            end else if (w_accept) begin
                if (r_state == S_LOAD_HI) begin
                    r_hi <= ld_nibble;
                end else if (r_state == S_LOAD_LO) begin
                    r_mem[r_ptr] <= {r_hi, ld_nibble};
                    if (r_ptr != 4'hF) r_ptr <= r_ptr + 4'd1;
                end
            end
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_xor <= 4'h0;
            r_err <= 1'b0;
        end else if (ld_start) begin
            r_xor <= 4'h0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (r_state != S_LOAD_SUM) begin
                r_xor <= r_xor ^ ld_nibble;
            end else if (ld_nibble != r_xor) begin
                r_err <= 1'b1;
            end
        end
    end
    assign ld_err = r_err;
`else
    assign ld_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_prog_mem : randomized self-checking bench for prog_mem against a    |
// | nibble-stream reference model.                        Rev 1.0          |
// +------------------------------------------------------------------------+
module tb_prog_mem;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic [3:0] addr      = 4'h0;
    logic [7:0] data;
    logic       cpu_run;
    logic       ld_start  = 1'b0;
    logic       ld_valid  = 1'b0;
    logic [3:0] ld_nibble = 4'h0;
    logic       ld_ready;
    logic       ld_done;
    logic       ld_err;

    int n_vec = 0;
    int n_err = 0;

    prog_mem #(.RESET_RUN(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .data      (data),
        .cpu_run   (cpu_run),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_nibble (ld_nibble),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .ld_err    (ld_err)
    );

    always #5 clock = ~clock;

`ifdef PROG_MEM_CHECKSUM_EN
    localparam int N_LOAD = 33;
`else
    localparam int N_LOAD = 32;
`endif

    // Reference model: a load is a stream of nibbles; odd-numbered ones complete an entry.
    logic [7:0] m_mem [16];
    bit         m_loading;
    bit         m_run;
    bit         m_done;
    bit         m_errf;
    int         m_cnt;
    logic [3:0] m_hi;
    logic [3:0] m_xor;

    task automatic tick(input bit s, input bit v, input logic [3:0] n);
        bit acc;
        ld_start  = s;
        ld_valid  = v;
        ld_nibble = n;
        addr      = 4'($urandom);
        acc = m_loading && v && !s;
        @(posedge clock);
        m_done = 0;
        if (s) begin
            m_loading = 1; m_cnt = 0; m_run = 0; m_errf = 0; m_xor = 4'h0;
        end else if (acc) begin
`ifdef PROG_MEM_CHECKSUM_EN
            if (m_cnt == 32) begin
                m_loading = 0;
                if (n == m_xor) begin m_run = 1; m_done = 1; end
                else m_errf = 1;
            end else
`endif
            begin
                if (m_cnt % 2 == 0) m_hi = n;
                else m_mem[m_cnt / 2] = {m_hi, n};
                m_xor = m_xor ^ n;
                m_cnt++;
`ifndef PROG_MEM_CHECKSUM_EN
                if (m_cnt == 32) begin m_loading = 0; m_run = 1; m_done = 1; end
`endif
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ld_start = 0; ld_valid = 0; ld_nibble = 4'h0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 0;
        idle_inputs();
        repeat (cycles) @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_loading = 0; m_run = 1; m_done = 0; m_errf = 0; m_cnt = 0; m_xor = 4'h0;
        reset = 1;
    endtask

    function automatic logic [3:0] pat_nib(input int k);
        logic [3:0] i4;
        i4 = 4'(k / 2);
        return (k % 2 == 0) ? i4 : ~i4;
    endfunction

    task automatic test_reset();
        apply_reset(2);
        n_vec++; if (cpu_run !== 1'b1) begin n_err++; $display("FAIL reset_cpu_run: got %b want 1", cpu_run); end
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        n_vec++; if (ld_done !== 1'b0) begin n_err++; $display("FAIL reset_ld_done: got %b want 0", ld_done); end
        n_vec++; if (ld_err !== 1'b0) begin n_err++; $display("FAIL reset_ld_err: got %b want 0", ld_err); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 00", a, data); end
        end
    endtask

    task automatic test_full_load();
        int done_cnt = 0;
        int done_at  = -1;
        logic [3:0] nib;
        tick(1, 0, 4'h0);
        for (int k = 0; k < N_LOAD; k++) begin
            nib = (k < 32) ? pat_nib(k) : 4'h0;
            tick(0, 1, nib);
            if (ld_done === 1'b1) begin done_cnt++; done_at = k; end
            n_vec++; if (ld_ready !== m_loading || cpu_run !== m_run || data !== m_mem[addr]) begin
                n_err++; $display("FAIL full_cycle[%0d]: ready=%b run=%b data=%h want ready=%b run=%b data=%h",
                                  k, ld_ready, cpu_run, data, m_loading, m_run, m_mem[addr]);
            end
        end
        n_vec++; if (done_cnt != 1 || done_at != N_LOAD - 1) begin
            n_err++; $display("FAIL full_done_pulse: count=%0d at=%0d want count=1 at=%0d", done_cnt, done_at, N_LOAD - 1);
        end
        tick(0, 0, 4'h0);
        n_vec++; if (ld_done !== 1'b0 || cpu_run !== 1'b1 || ld_err !== 1'b0) begin
            n_err++; $display("FAIL full_after: done=%b run=%b err=%b want 0 1 0", ld_done, cpu_run, ld_err);
        end
        idle_inputs();
        addr = 4'd5; #1;
        n_vec++; if (data !== 8'h5A) begin n_err++; $display("FAIL full_addr5: got %h want 5a", data); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== {4'(a), ~4'(a)}) begin
                n_err++; $display("FAIL full_data[%0d]: got %h want %h", a, data, {4'(a), ~4'(a)});
            end
        end
    endtask

    task automatic test_random_valid();
        int  acc = 0;
        int  guard = 0;
        int  done_cnt = 0;
        bit  v;
        logic [3:0] nib;
        apply_reset(1);
        tick(1, 0, 4'h0);
        while (acc < N_LOAD && guard < 400) begin
            v   = ($urandom % 2) == 1;
            nib = v ? ((acc < 32) ? pat_nib(acc) : 4'h0) : 4'($urandom);
            tick(0, v, nib);
            if (v) acc++;
            guard++;
            if (ld_done === 1'b1) done_cnt++;
            n_vec++; if (ld_ready !== m_loading || cpu_run !== m_run || ld_done !== m_done || data !== m_mem[addr]) begin
                n_err++; $display("FAIL rand_cycle[%0d]: ready=%b run=%b done=%b data=%h want %b %b %b %h",
                                  guard, ld_ready, cpu_run, ld_done, data, m_loading, m_run, m_done, m_mem[addr]);
            end
        end
        n_vec++; if (acc != N_LOAD || done_cnt != 1) begin
            n_err++; $display("FAIL rand_complete: accepts=%0d done=%0d want %0d 1", acc, done_cnt, N_LOAD);
        end
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== {4'(a), ~4'(a)}) begin
                n_err++; $display("FAIL rand_data[%0d]: got %h want %h", a, data, {4'(a), ~4'(a)});
            end
        end
    endtask

    task automatic test_restart();
        logic [3:0] hi2, lo2;
        tick(1, 0, 4'h0);
        for (int k = 0; k < 9; k++) tick(0, 1, 4'($urandom));
        tick(1, 1, 4'($urandom));
        n_vec++; if (ld_ready !== 1'b1 || cpu_run !== 1'b0) begin
            n_err++; $display("FAIL restart_state: ready=%b run=%b want 1 0", ld_ready, cpu_run);
        end
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== m_mem[a] || (a >= 4 && data !== {4'(a), ~4'(a)})) begin
                n_err++; $display("FAIL restart_retain[%0d]: got %h want %h", a, data, m_mem[a]);
            end
        end
        hi2 = 4'($urandom); lo2 = 4'($urandom);
        tick(0, 1, hi2);
        idle_inputs(); addr = 4'd0; #1;
        n_vec++; if (data !== m_mem[0]) begin n_err++; $display("FAIL restart_hi_only: got %h want %h", data, m_mem[0]); end
        tick(0, 1, lo2);
        idle_inputs(); addr = 4'd0; #1;
        n_vec++; if (data !== {hi2, lo2}) begin n_err++; $display("FAIL restart_entry0: got %h want %h", data, {hi2, lo2}); end
        addr = 4'd1; #1;
        n_vec++; if (data !== m_mem[1]) begin n_err++; $display("FAIL restart_entry1: got %h want %h", data, m_mem[1]); end
        for (int k = 2; k < 32; k++) tick(0, 1, 4'($urandom));
`ifdef PROG_MEM_CHECKSUM_EN
        tick(0, 1, m_xor);
`endif
        n_vec++; if (ld_done !== 1'b1 || cpu_run !== 1'b1 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL restart_finish: done=%b run=%b ready=%b want 1 1 0", ld_done, cpu_run, ld_ready);
        end
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== m_mem[a]) begin n_err++; $display("FAIL restart_data[%0d]: got %h want %h", a, data, m_mem[a]); end
        end
    endtask

    task automatic test_reset_midload();
        tick(1, 0, 4'h0);
        for (int k = 0; k < 10; k++) tick(0, 1, 4'($urandom));
        reset = 0; ld_valid = 1; ld_start = 1; ld_nibble = 4'($urandom);
        @(posedge clock); #1;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_loading = 0; m_run = 1; m_done = 0; m_errf = 0; m_cnt = 0;
        reset = 1; ld_start = 0;
        n_vec++; if (ld_ready !== 1'b0 || cpu_run !== 1'b1 || ld_done !== 1'b0 || ld_err !== 1'b0) begin
            n_err++; $display("FAIL midreset_flags: ready=%b run=%b done=%b err=%b want 0 1 0 0", ld_ready, cpu_run, ld_done, ld_err);
        end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); @(negedge clock);
            n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL midreset_data[%0d]: got %h want 00", a, data); end
        end
        idle_inputs();
    endtask

`ifdef PROG_MEM_CHECKSUM_EN
    task automatic test_checksum();
        tick(1, 0, 4'h0);
        for (int k = 0; k < 32; k++) tick(0, 1, pat_nib(k));
        tick(0, 1, 4'h1);
        n_vec++; if (ld_err !== 1'b1 || cpu_run !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0) begin
            n_err++; $display("FAIL sum_bad: err=%b run=%b ready=%b done=%b want 1 0 0 0", ld_err, cpu_run, ld_ready, ld_done);
        end
        for (int k = 0; k < 4; k++) tick(0, 1, 4'($urandom));
        n_vec++; if (ld_err !== m_errf || cpu_run !== 1'b0 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL sum_err_hold: err=%b run=%b ready=%b want %b 0 0", ld_err, cpu_run, ld_ready, m_errf);
        end
        tick(1, 0, 4'h0);
        n_vec++; if (ld_err !== 1'b0 || ld_ready !== 1'b1) begin
            n_err++; $display("FAIL sum_restart: err=%b ready=%b want 0 1", ld_err, ld_ready);
        end
        for (int k = 0; k < 32; k++) tick(0, 1, pat_nib(k));
        tick(0, 1, 4'h0);
        n_vec++; if (ld_done !== 1'b1 || cpu_run !== 1'b1 || ld_err !== 1'b0) begin
            n_err++; $display("FAIL sum_good: done=%b run=%b err=%b want 1 1 0", ld_done, cpu_run, ld_err);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_random_valid();
        test_restart();
        test_reset_midload();
`ifdef PROG_MEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
